// File: rtl/mobo_arbiter_if.sv
// Bundles both requester ports and the motherboard transaction port of mobo_arbiter.
// Handshake: rN_req is held until the one-cycle rN_ack; rN_err qualifies rN_ack and is 0 otherwise.
interface mobo_arbiter_if #(
  parameter int word_width = 32
);
  logic                  r0_req;
  logic                  r0_we;
  logic [word_width-1:0] r0_addr;
  logic [word_width-1:0] r0_wdata;
  logic [word_width-1:0] r0_rdata;
  logic                  r0_ack;
  logic                  r0_err;

  logic                  r1_req;
  logic                  r1_we;
  logic [word_width-1:0] r1_addr;
  logic [word_width-1:0] r1_wdata;
  logic [word_width-1:0] r1_rdata;
  logic                  r1_ack;
  logic                  r1_err;

  logic [word_width-1:0] mobo_ctrl;
  logic [word_width-1:0] mobo_stat;
  logic [word_width-1:0] mobo_addr;
  logic [word_width-1:0] mobo_wdata;
  logic [word_width-1:0] mobo_rdata;

  logic                  busy;
  logic                  grant;
  logic [1:0]            state_dbg;

  // Arbiter side.
  modport master (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mobo_stat, mobo_rdata,
    output r0_rdata, r0_ack, r0_err,
    output r1_rdata, r1_ack, r1_err,
    output mobo_ctrl, mobo_addr, mobo_wdata,
    output busy, grant, state_dbg
  );

  // Requesters and motherboard side.
  modport slave (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mobo_stat, mobo_rdata,
    input  r0_rdata, r0_ack, r0_err,
    input  r1_rdata, r1_ack, r1_err,
    input  mobo_ctrl, mobo_addr, mobo_wdata,
    input  busy, grant, state_dbg
  );
endinterface

// File: rtl/mobo_arbiter.sv
// Round-robin arbiter sharing the motherboard transaction port between two requesters,
// sequencing IDLE -> command -> DONE -> IDLE and returning a one-cycle ack (or timeout error).
module mobo_arbiter #(
  parameter int word_width = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic           clk,
  input  logic           rst,
  mobo_arbiter_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [word_width-1:0] CTRL_NONE  = word_width'(0);
  localparam logic [word_width-1:0] CTRL_READ  = word_width'(1);
  localparam logic [word_width-1:0] CTRL_WRITE = word_width'(2);
  localparam logic [word_width-1:0] MOBO_IDLE  = word_width'(0);
  localparam logic [word_width-1:0] MOBO_DONE  = word_width'(2);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_WAIT_IDLE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [word_width-1:0] ctrl_q, ctrl_d;
  logic [word_width-1:0] addr_q, addr_d;
  logic [word_width-1:0] wdata_q, wdata_d;
  logic [word_width-1:0] r0_rdata_q, r0_rdata_d;
  logic [word_width-1:0] r1_rdata_q, r1_rdata_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r0_err_q, r0_err_d;
  logic                  r1_ack_q, r1_ack_d;
  logic                  r1_err_q, r1_err_d;
  logic                  busy_q, busy_d;
  logic                  grant_q, grant_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic winner;
  logic any_req;
  logic ack_d;
  logic err_d;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    any_req = bus.r0_req | bus.r1_req;
    // Only a tie consults the previous owner; a lone requester always wins.
    winner  = (bus.r0_req && bus.r1_req) ? ~grant_q : bus.r1_req;

    case (state_q)
      S_IDLE: begin
        ctrl_d = CTRL_NONE;
        if (any_req && (bus.mobo_stat == MOBO_IDLE)) begin
          grant_d = winner;
          addr_d  = winner ? bus.r1_addr  : bus.r0_addr;
          wdata_d = winner ? bus.r1_wdata : bus.r0_wdata;
          ctrl_d  = (winner ? bus.r1_we : bus.r0_we) ? CTRL_WRITE : CTRL_READ;
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + 1'b1;
        // DONE takes priority over a timeout landing on the same cycle.
        if (bus.mobo_stat == MOBO_DONE) begin
          if (grant_q) r1_rdata_d = bus.mobo_rdata;
          else         r0_rdata_d = bus.mobo_rdata;
          ack_d   = 1'b1;
          ctrl_d  = CTRL_NONE;
          state_d = S_WAIT_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          ctrl_d  = CTRL_NONE;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        ctrl_d = CTRL_NONE;
        if (bus.mobo_stat == MOBO_IDLE) state_d = S_IDLE;
      end
      default: begin
        ctrl_d  = CTRL_NONE;
        state_d = S_IDLE;
      end
    endcase

    r0_ack_d = ack_d & ~grant_q;
    r0_err_d = err_d & ~grant_q;
    r1_ack_d = ack_d & grant_q;
    r1_err_d = err_d & grant_q;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= CTRL_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      r0_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b1;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_ack_q   <= r0_ack_d;
      r0_err_q   <= r0_err_d;
      r1_ack_q   <= r1_ack_d;
      r1_err_q   <= r1_err_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.mobo_ctrl  = ctrl_q;
  assign bus.mobo_addr  = addr_q;
  assign bus.mobo_wdata = wdata_q;
  assign bus.r0_rdata   = r0_rdata_q;
  assign bus.r0_ack     = r0_ack_q;
  assign bus.r0_err     = r0_err_q;
  assign bus.r1_rdata   = r1_rdata_q;
  assign bus.r1_ack     = r1_ack_q;
  assign bus.r1_err     = r1_err_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_mobo_arbiter.sv
// Directed bench for mobo_arbiter with a small motherboard model that raises DONE
// a programmable number of cycles after a command appears.
module tb_mobo_arbiter;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mobo_arbiter_if #(.word_width(W)) bus ();

  mobo_arbiter #(.word_width(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Motherboard model: done_at=0 means never DONE; force_busy pins status to BUSY.
  int              done_at    = 0;
  bit              force_busy = 1'b0;
  logic [W-1:0]    mdl_rdata  = '0;
  int              mdl_cnt    = 0;

  always @(negedge clk) begin
    if (force_busy) begin
      mdl_cnt = 0;
      bus.mobo_stat = W'(1);
    end else if (bus.mobo_ctrl != '0) begin
      mdl_cnt++;
      bus.mobo_stat = (done_at != 0 && mdl_cnt >= done_at) ? W'(2) : W'(1);
    end else begin
      mdl_cnt = 0;
      bus.mobo_stat = W'(0);
    end
    bus.mobo_rdata = mdl_rdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Ticks until requester `who` acks (bounded); reports ticks taken and any ack from the other side.
  task automatic wait_ack(input int who, input int limit, output int n, output bit seen, output bit other);
    n = 0; seen = 1'b0; other = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick;
      n++;
      if ((who == 0) ? bus.r1_ack : bus.r0_ack) other = 1'b1;
      if ((who == 0) ? bus.r0_ack : bus.r1_ack) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int limit);
    for (int i = 0; i < limit && bus.mobo_ctrl == '0; i++) tick;
  endtask

  task automatic test_reset;
    clear_reqs;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++; if (bus.mobo_ctrl !== '0) begin n_bad++; $display("FAIL reset_ctrl got=%0h exp=0", bus.mobo_ctrl); end
    n_cmp++; if (bus.mobo_addr !== '0) begin n_bad++; $display("FAIL reset_addr got=%0h exp=0", bus.mobo_addr); end
    n_cmp++; if (bus.mobo_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata got=%0h exp=0", bus.mobo_wdata); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.grant !== 1'b1) begin n_bad++; $display("FAIL reset_grant got=%b exp=1", bus.grant); end
    n_cmp++; if (bus.state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
    n_cmp++; if ({bus.r0_ack, bus.r0_err, bus.r1_ack, bus.r1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err got=%b exp=0000", {bus.r0_ack, bus.r0_err, bus.r1_ack, bus.r1_err}); end
    n_cmp++; if (bus.r0_rdata !== '0 || bus.r1_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", bus.r0_rdata, bus.r1_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    int n; bit seen, other;
    done_at = 4; mdl_rdata = W'(32'hDEAD);
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = W'(32'h10);
    tick;
    n_cmp++; if (bus.mobo_ctrl !== W'(1)) begin n_bad++; $display("FAIL single_ctrl got=%0h exp=1", bus.mobo_ctrl); end
    n_cmp++; if (bus.mobo_addr !== W'(32'h10)) begin n_bad++; $display("FAIL single_addr got=%0h exp=10", bus.mobo_addr); end
    n_cmp++; if (bus.busy !== 1'b1 || bus.grant !== 1'b0) begin n_bad++; $display("FAIL single_busy_grant got=%b%b exp=10", bus.busy, bus.grant); end
    wait_ack(0, 20, n, seen, other);
    n_cmp++; if (!seen || n != 4) begin n_bad++; $display("FAIL single_latency got=%0d seen=%b exp=4", n, seen); end
    n_cmp++; if (bus.r0_rdata !== W'(32'hDEAD) || bus.r0_err !== 1'b0) begin n_bad++; $display("FAIL single_rdata got=%0h err=%b exp=dead err=0", bus.r0_rdata, bus.r0_err); end
    n_cmp++; if (bus.mobo_ctrl !== '0 || other) begin n_bad++; $display("FAIL single_ctrl_off got=%0h other=%b exp=0 0", bus.mobo_ctrl, other); end
    bus.r0_req = 1'b0;
    tick;
    n_cmp++; if (bus.r0_ack !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_after got ack=%b busy=%b exp=0 0", bus.r0_ack, bus.busy); end
  endtask

  task automatic test_back_to_back;
    int n; bit seen, other;
    pulse_reset;
    done_at = 2; mdl_rdata = W'(32'hA0);
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = W'(4); bus.r0_wdata = W'(7);
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = W'(8);
    tick;
    n_cmp++; if (bus.mobo_ctrl !== W'(2) || bus.mobo_wdata !== W'(7) || bus.mobo_addr !== W'(4)) begin n_bad++; $display("FAIL rr_first got ctrl=%0h wd=%0h ad=%0h exp=2 7 4", bus.mobo_ctrl, bus.mobo_wdata, bus.mobo_addr); end
    n_cmp++; if (bus.grant !== 1'b0) begin n_bad++; $display("FAIL rr_first_grant got=%b exp=0", bus.grant); end
    wait_ack(0, 20, n, seen, other);
    n_cmp++; if (!seen || other) begin n_bad++; $display("FAIL rr_ack0 got seen=%b other=%b exp=1 0", seen, other); end
    mdl_rdata = W'(32'hB1);
    wait_grant(10);
    n_cmp++; if (bus.mobo_ctrl !== W'(1) || bus.mobo_addr !== W'(8) || bus.grant !== 1'b1) begin n_bad++; $display("FAIL rr_second got ctrl=%0h ad=%0h g=%b exp=1 8 1", bus.mobo_ctrl, bus.mobo_addr, bus.grant); end
    wait_ack(1, 20, n, seen, other);
    n_cmp++; if (!seen || other || bus.r1_rdata !== W'(32'hB1)) begin n_bad++; $display("FAIL rr_ack1 got seen=%b other=%b rd=%0h exp=1 0 b1", seen, other, bus.r1_rdata); end
    n_cmp++; if (bus.r0_rdata !== W'(32'hA0)) begin n_bad++; $display("FAIL rr_r0_hold got=%0h exp=a0", bus.r0_rdata); end
    mdl_rdata = W'(32'hC2);
    wait_grant(10);
    n_cmp++; if (bus.mobo_ctrl !== W'(2) || bus.grant !== 1'b0) begin n_bad++; $display("FAIL rr_third got ctrl=%0h g=%b exp=2 0", bus.mobo_ctrl, bus.grant); end
    wait_ack(0, 20, n, seen, other);
    n_cmp++; if (!seen || other || bus.r0_rdata !== W'(32'hC2)) begin n_bad++; $display("FAIL rr_ack0b got seen=%b other=%b rd=%0h exp=1 0 c2", seen, other, bus.r0_rdata); end
    clear_reqs;
    tick;
    tick;
    n_cmp++; if (bus.busy !== 1'b0 || bus.mobo_ctrl !== '0) begin n_bad++; $display("FAIL rr_idle got busy=%b ctrl=%0h exp=0 0", bus.busy, bus.mobo_ctrl); end
  endtask

  task automatic test_not_idle;
    int n; bit seen, other;
    done_at = 2; mdl_rdata = W'(32'h33);
    force_busy = 1'b1;
    tick;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = W'(32'h20);
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (bus.mobo_ctrl !== '0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_hold[%0d] got ctrl=%0h busy=%b exp=0 0", i, bus.mobo_ctrl, bus.busy); end
    end
    force_busy = 1'b0;
    tick;
    n_cmp++; if (bus.mobo_ctrl !== W'(1) || bus.grant !== 1'b1 || bus.mobo_addr !== W'(32'h20)) begin n_bad++; $display("FAIL busy_grant got ctrl=%0h g=%b ad=%0h exp=1 1 20", bus.mobo_ctrl, bus.grant, bus.mobo_addr); end
    wait_ack(1, 20, n, seen, other);
    n_cmp++; if (!seen || bus.r1_rdata !== W'(32'h33) || bus.r0_rdata !== W'(32'hC2)) begin n_bad++; $display("FAIL busy_ack got seen=%b rd1=%0h rd0=%0h exp=1 33 c2", seen, bus.r1_rdata, bus.r0_rdata); end
    clear_reqs;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int n; bit seen, other;
    done_at = 0; mdl_rdata = W'(32'h99);
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = W'(32'h30);
    tick;
    wait_ack(0, 30, n, seen, other);
    n_cmp++; if (!seen || n != TO) begin n_bad++; $display("FAIL to_latency got=%0d seen=%b exp=%0d", n, seen, TO); end
    n_cmp++; if (bus.r0_err !== 1'b1 || bus.mobo_ctrl !== '0) begin n_bad++; $display("FAIL to_err got err=%b ctrl=%0h exp=1 0", bus.r0_err, bus.mobo_ctrl); end
    n_cmp++; if (bus.r0_rdata !== W'(32'hC2)) begin n_bad++; $display("FAIL to_rdata got=%0h exp=c2", bus.r0_rdata); end
    clear_reqs;
    tick;
    n_cmp++; if (bus.r0_ack !== 1'b0 || bus.r0_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse got ack=%b err=%b exp=0 0", bus.r0_ack, bus.r0_err); end
    tick;
  endtask

  task automatic test_done_at_timeout;
    int n; bit seen, other;
    done_at = TO; mdl_rdata = W'(32'hBEEF);
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = W'(32'h34);
    tick;
    wait_ack(0, 30, n, seen, other);
    n_cmp++; if (!seen || n != TO) begin n_bad++; $display("FAIL tie_latency got=%0d seen=%b exp=%0d", n, seen, TO); end
    n_cmp++; if (bus.r0_err !== 1'b0 || bus.r0_rdata !== W'(32'hBEEF)) begin n_bad++; $display("FAIL tie_done got err=%b rd=%0h exp=0 beef", bus.r0_err, bus.r0_rdata); end
    clear_reqs;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_op;
    int n; bit seen, other;
    done_at = 0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = W'(32'h38);
    tick;
    tick;
    tick;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    tick;
    n_cmp++; if (bus.mobo_ctrl !== '0 || bus.busy !== 1'b0 || bus.grant !== 1'b1 || bus.r0_ack !== 1'b0) begin n_bad++; $display("FAIL mid_reset got ctrl=%0h busy=%b g=%b ack=%b exp=0 0 1 0", bus.mobo_ctrl, bus.busy, bus.grant, bus.r0_ack); end
    rst = 1'b0;
    clear_reqs;
    tick;
    n_cmp++; if (bus.r0_ack !== 1'b0 || bus.r0_rdata !== '0) begin n_bad++; $display("FAIL mid_noack got ack=%b rd=%0h exp=0 0", bus.r0_ack, bus.r0_rdata); end
    done_at = 2; mdl_rdata = W'(32'h5A5A);
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = W'(32'h40);
    tick;
    n_cmp++; if (bus.mobo_ctrl !== W'(1) || bus.grant !== 1'b1 || bus.mobo_addr !== W'(32'h40)) begin n_bad++; $display("FAIL mid_regrant got ctrl=%0h g=%b ad=%0h exp=1 1 40", bus.mobo_ctrl, bus.grant, bus.mobo_addr); end
    wait_ack(1, 20, n, seen, other);
    n_cmp++; if (!seen || bus.r1_err !== 1'b0 || bus.r1_rdata !== W'(32'h5A5A)) begin n_bad++; $display("FAIL mid_ack got seen=%b err=%b rd=%0h exp=1 0 5a5a", seen, bus.r1_err, bus.r1_rdata); end
    clear_reqs;
    tick;
    tick;
  endtask

  initial begin
    clear_reqs;
    test_reset;
    test_single_read;
    test_back_to_back;
    test_not_idle;
    test_timeout;
    test_done_at_timeout;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mobo_arbiter.md
Name: mobo_arbiter

Overview:
- Shares the single motherboard transaction port (mobo_ctrl / mobo_stat / address / data) between two requesters.
- Requester 0 is the CPU core FSM; requester 1 is a loader/debug/DMA master.
- Arbitrates round-robin and sequences the full IDLE -> command -> DONE -> IDLE handshake on the requester's behalf. Returns read data with a one-cycle ack, or an error on timeout.

Parameters:
word_width, 32, width of address, data, mobo_ctrl and mobo_stat
TIMEOUT, 1024, max cycles in WAIT_DONE before abort; must be >= 2

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
r0_req  in  1  requester 0 transaction request; held until r0_ack
r0_we  in  1  1=write, 0=read
r0_addr  in  word_width  transaction address
r0_wdata  in  word_width  write data
r0_rdata  out  word_width  read data, valid when r0_ack=1
r0_ack  out  1  one-cycle completion pulse
r0_err  out  1  qualifies r0_ack; 1 = timed out
r1_req, r1_we, r1_addr, r1_wdata, r1_rdata, r1_ack, r1_err  same as r0_*, for requester 1
mobo_ctrl  out  word_width  command to motherboard: CTRL_NONE=0, CTRL_READ=1, CTRL_WRITE=2
mobo_stat  in  word_width  motherboard status: MOBO_IDLE=0, MOBO_BUSY=1, MOBO_DONE=2
mobo_addr  out  word_width  registered transaction address
mobo_wdata  out  word_width  registered write data
mobo_rdata  in  word_width  read data, valid while mobo_stat==MOBO_DONE
busy  out  1  1 whenever state != IDLE
grant  out  1  index of current/last owner

Behaviour:
- All outputs are registered. On rst:
  - state=IDLE; mobo_ctrl=CTRL_NONE; mobo_addr=0; mobo_wdata=0.
  - rN_rdata=0, rN_ack=0, rN_err=0; busy=0; timer=0.
  - grant=1, so requester 0 wins the first tie.
- rst mid-transaction: aborts immediately, no ack is issued, and mobo_ctrl returns to CTRL_NONE the next cycle.
- States: IDLE, WAIT_DONE, WAIT_IDLE.
- IDLE:
  - Grants only if at least one req=1 and mobo_stat==MOBO_IDLE.
  - If only one requester is requesting, it wins. If both are requesting, the winner is !grant (round-robin).
  - On the grant edge, latch the winner's addr/wdata into mobo_addr/mobo_wdata, set grant=winner, and set mobo_ctrl = we ? CTRL_WRITE : CTRL_READ. Clear timer and go to WAIT_DONE.
  - If mobo_stat != MOBO_IDLE, stay in IDLE and hold mobo_ctrl=CTRL_NONE.
- WAIT_DONE:
  - mobo_ctrl is held; timer increments each cycle.
  - If mobo_stat==MOBO_DONE: capture mobo_rdata into r<grant>_rdata (writes also capture it; the value is don't-care). Pulse r<grant>_ack=1 with err=0 on the next cycle, set mobo_ctrl=CTRL_NONE, go to WAIT_IDLE.
  - Else if timer==TIMEOUT-1: pulse r<grant>_ack=1 with err=1 and leave rdata unchanged. Set mobo_ctrl=CTRL_NONE, go to WAIT_IDLE.
  - If DONE arrives in the same cycle as the timeout, DONE wins (err=0).
- WAIT_IDLE:
  - mobo_ctrl=CTRL_NONE; go to IDLE once mobo_stat==MOBO_IDLE.
  - Minimum one cycle in this state. This guarantees a requester that drops req on ack is never re-granted.
- Command-to-ack latency:
  - The grant edge drives the command.
  - Ack is asserted the cycle after DONE is first sampled.
  - The next grant is at earliest 2 cycles after ack.
- Only the granted requester's ack/err/rdata ever change. The other requester's outputs hold their values.
- rN_ack is high for exactly one cycle per granted transaction. rN_err is 0 whenever rN_ack is 0.
- Request inputs are sampled only in IDLE. Changes to addr/we/wdata after the grant do not affect the transaction in flight.
- Timer is $clog2(TIMEOUT) bits wide and never wraps: it is cleared on every grant.

Test Plan:
- Single read: r0 req, addr=0x10. Model asserts DONE 3 cycles after CTRL_READ with rdata=0xDEAD. Expected: mobo_ctrl=1 for 4 cycles, r0_ack one cycle with r0_rdata=0xDEAD, r0_err=0, busy returns to 0.
- Simultaneous requests from reset: r0 write (addr=4, wdata=7) and r1 read (addr=8), both held. Expected: r0 served first (mobo_ctrl=2, mobo_wdata=7), then r1 (mobo_ctrl=1, mobo_addr=8). Repeat the pair: r0, r1 alternate and r1_ack never coincides with r0_ack.
- Motherboard not idle: mobo_stat=MOBO_BUSY while r1_req=1 for 5 cycles. Expected: mobo_ctrl stays 0 and no grant; the grant occurs on the first cycle with mobo_stat=0.
- Timeout: TIMEOUT=8, model never asserts DONE. Expected: r0_ack=1 with r0_err=1 on the cycle after 8 WAIT_DONE cycles, mobo_ctrl back to 0, r0_rdata unchanged.
- DONE and timeout coincide: DONE on the final timer cycle. Expected: err=0 and rdata captured.
- Reset mid-op: rst asserted during WAIT_DONE. Expected: next cycle mobo_ctrl=0, busy=0, grant=1, no ack; the subsequent r1-only request is granted normally.
